vehicle_cmd_sequencer: RTL
==========================

// Module: vehicle_cmd_sequencer
// PURPOSE
//   Shares one single-shot command unit (start/done/result handshake, e.g. disarm_vehicle) among
//   NUM_REQ requesters. Round-robin arbitration, one-cycle start pulse, done/timeout watchdog,
//   per-requester ack/err pulse with captured result. Sits between flight-command sources and unit.
// PARAMETERS
//   NUM_REQ  4    number of requesters (2..16); GRANT_W = $clog2(NUM_REQ) derived localparam
//   TIMEOUT  256  max WAIT cycles before abort (>=4, fits 16 bits)
//   RES_W    32   unit result width
// PORTS
//   clk            in   1        system clock, rising edge
//   rst_n          in   1        asynchronous active-low reset
//   req            in   NUM_REQ  level request per requester; held until own ack/err
//   ack            out  NUM_REQ  one-cycle pulse: granted command completed OK
//   err            out  NUM_REQ  one-cycle pulse: granted command timed out
//   rsp_result     out  RES_W    result for the ack/err pulse; held until next RESP
//   grant_id       out  GRANT_W  index of current/last granted requester
//   busy           out  1        high in any state except IDLE
//   unit_start     out  1        start to command unit; high exactly one cycle (START)
//   unit_done      in   1        command unit done (level, unit clears it after sampling start)
//   unit_result    in   RES_W    command unit result, valid while unit_done high
//   timeout_count  out  8        saturating count of timeouts since reset
// BEHAVIOUR
//   Reset: state=IDLE; ack=0, err=0, rsp_result=0, grant_id=0, busy=0, unit_start=0,
//     timeout_count=0, last_grant=NUM_REQ-1 (requester 0 has first priority). All outputs registered.
//   FSM IDLE -> START -> WAIT -> RESP -> IDLE:
//   - IDLE: if |req, pick first set bit scanning last_grant+1, +2, ... modulo NUM_REQ;
//     load grant_id, -> START. No req: stay.
//   - START: unit_start=1 for this cycle only; wait timer cleared to 0; -> WAIT.
//   - WAIT: unit_done sampled only here. unit_done=1: capture unit_result, -> RESP(ok).
//     Else timer==TIMEOUT-1: rsp_result<=0, -> RESP(timeout). Else timer+1.
//     unit_done and timer expiry same cycle: done wins (ok).
//   - RESP: ack[grant_id]=1 (ok) or err[grant_id]=1 (timeout) for one cycle, never both,
//     never two bits set; last_grant<=grant_id; timeout: timeout_count+1, saturates at 255; -> IDLE.
//   - Latency: req sampled in IDLE at edge E; unit_start high cycle E..E+1; unit taking D cycles
//     from start sample to done high -> ack high D+2 cycles after unit_start cycle.
//   - Min back-to-back spacing: 4 cycles per command (IDLE one cycle even when req pending).
//   - req dropped after grant: command still runs to completion; ack/err still pulses.
//   - req changes while busy: ignored until next IDLE.
//   - Same requester re-requests: gets lowest priority next arbitration if others pending.
//   - unit_done high in IDLE/START/RESP: ignored.
//   - Reset mid-operation: immediate return to reset values incl. unit_start=0; in-flight
//     command dropped, no ack/err.
//   - Timer 16 bits; no wrap possible since TIMEOUT <= 65535.
// TESTING
//   1 Single req[2]=1; unit done 3 cycles after start -> one unit_start pulse, ack=4'b0100
//     5 cycles after unit_start, rsp_result=unit_result (e.g. 32'hDEAD_BEEF), grant_id=2.
//   2 req=4'b1111 held, ack per requester -> grant order 0,1,2,3,0; exactly one ack per cmd.
//   3 Unit never asserts done, TIMEOUT=8 -> err[grant] pulse after 8 WAIT cycles,
//     rsp_result=0, timeout_count 0->1; 300 timeouts -> timeout_count=255.
//   4 unit_done rises on the cycle timer==TIMEOUT-1 -> ack not err, result captured.
//   5 rst_n low during WAIT -> all outputs 0 asynchronously; release, req[0] -> grant_id=0, normal.
//   6 req[1] drops one cycle after grant, unit_done held high in IDLE -> ack[1] still pulses;
//     no spurious start, done in IDLE ignored.

Source files
------------

// File: rtl/vehicle_cmd_sequencer.sv
// rtl/vehicle_cmd_sequencer.sv - round-robin sharing of one single-shot command unit among NUM_REQ requesters
module vehicle_cmd_sequencer #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 256,
    parameter int RES_W   = 32,
    localparam int GRANT_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] err,
    output logic [RES_W-1:0]   rsp_result,
    output logic [GRANT_W-1:0] grant_id,
    output logic               busy,
    output logic               unit_start,
    input  logic               unit_done,
    input  logic [RES_W-1:0]   unit_result,
    output logic [7:0]         timeout_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [GRANT_W-1:0]   last_q, last_d;
    logic [15:0]          timer_q, timer_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic [RES_W-1:0]     result_q, result_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic [7:0]           tcount_q, tcount_d;

    logic [GRANT_W-1:0]   pick;
    logic [GRANT_W-1:0]   cand;
    logic                 found;

    // Scan starts just after the last served requester so it drops to lowest priority.
    always_comb begin
        pick  = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = GRANT_W'((int'(last_q) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        timer_d  = timer_q;
        ack_d    = '0;
        err_d    = '0;
        result_d = result_q;
        start_d  = 1'b0;
        tcount_d = tcount_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    start_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the expiry cycle still counts as success.
                if (unit_done) begin
                    result_d       = unit_result;
                    ack_d[grant_q] = 1'b1;
                    state_d        = S_RESP;
                end else if (timer_q == 16'(TIMEOUT - 1)) begin
                    result_d       = '0;
                    err_d[grant_q] = 1'b1;
                    state_d        = S_RESP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_RESP: begin
                last_d = grant_q;
                if ((|err_q) && (tcount_q != 8'hFF)) begin
                    tcount_d = tcount_q + 8'd1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            last_q   <= GRANT_W'(NUM_REQ - 1);
            timer_q  <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            result_q <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            tcount_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            result_q <= result_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            tcount_q <= tcount_d;
        end
    end

    assign ack           = ack_q;
    assign err           = err_q;
    assign rsp_result    = result_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign unit_start    = start_q;
    assign timeout_count = tcount_q;

endmodule
